signed_8bit_divider: RTL

SIGNED_8BIT_DIVIDER -- requirements
Module: signed_8bit_divider

---
 rtl/signed_8bit_divider.sv | 108 ++++++++++
 1 files changed

// File: rtl/signed_8bit_divider.sv
// Signed 8-bit restoring divider: sign/magnitude capture, 8 shift-subtract steps, sign fix-up.
// Build option: define SIGNED_DIV_EARLY_ZERO_EN to finish zero-divisor requests one cycle after acceptance.
module signed_8bit_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output logic       overflow
);

`ifdef SIGNED_DIV_EARLY_ZERO_EN
  localparam bit EARLY_ZERO = 1'b1;
`else
  localparam bit EARLY_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t     state, next_state;
  logic [2:0] count;
  logic [8:0] part_rem;
  logic [7:0] quo_sh;
  logic [7:0] dvd_q, dvs_q;

  logic       accept, load;
  logic [7:0] b_mag;
  logic [8:0] shifted, diff;
  logic       ge;
  logic [7:0] q_signed, r_signed;
  logic       is_zero, is_ovf;

  function automatic logic [7:0] mag8(input logic [7:0] v);
    return v[7] ? 8'(-v) : v;  // |-128| = 128 still fits unsigned 8 bits
  endfunction

  // A pending early zero-divisor result sits in IDLE with busy set, so busy also blocks start.
  assign accept = (state == IDLE) && start && !busy;
  assign load   = (state == SIGN) || (EARLY_ZERO && (state == IDLE) && busy);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept && !(EARLY_ZERO && (divisor == 8'd0))) next_state = CALC;
      CALC: if (count == 3'd7) next_state = SIGN;
      SIGN: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    b_mag    = mag8(dvs_q);
    shifted  = {part_rem[7:0], quo_sh[7]};
    ge       = part_rem[8] || (shifted >= {1'b0, b_mag});
    diff     = shifted - {1'b0, b_mag};
    q_signed = (dvd_q[7] ^ dvs_q[7]) ? 8'(-quo_sh) : quo_sh;
    r_signed = dvd_q[7] ? 8'(-part_rem[7:0]) : part_rem[7:0];
    is_zero  = (dvs_q == 8'd0);
    is_ovf   = (dvd_q == 8'h80) && (dvs_q == 8'hFF);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      part_rem    <= '0;
      quo_sh      <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      if (accept) begin
        dvd_q    <= dividend;
        dvs_q    <= divisor;
        quo_sh   <= mag8(dividend);
        part_rem <= '0;
        count    <= '0;
        busy     <= 1'b1;
      end else if (state == CALC) begin
        part_rem <= ge ? diff : shifted;
        quo_sh   <= {quo_sh[6:0], ge};
        count    <= count + 3'd1;
      end else if (load) begin
        quotient    <= is_zero ? 8'hFF : q_signed;
        remainder   <= is_zero ? dvd_q : r_signed;
        div_by_zero <= is_zero;
        overflow    <= is_ovf;
        busy        <= 1'b0;
        done        <= 1'b1;
      end
    end
  end

endmodule
